// File: rtl/pdm_seq_pkg.sv
// pdm_seq_pkg
// Shared definitions for the PDM level sequencer: FSM state encoding and
// default parameter values used by pdm_level_sequencer and pdm_seq_timer.
// No ports.
package pdm_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } pdm_seq_state_e;

    localparam int PDM_SEQ_LEVEL_W = 5;
    localparam int PDM_SEQ_DEPTH   = 8;
    localparam int PDM_SEQ_PERIOD  = 64;

endpackage

// File: rtl/pdm_seq_timer.sv
// pdm_seq_timer
// Period counter for the level sequencer. Counts 0..PERIOD-1 while enabled
// and raises tick for the single cycle in which the count sits at PERIOD-1
// (the cycle before it wraps back to 0).
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : synchronous, active-high
//   clr_i  in  : force the count to 0 (takes priority over en_i)
//   en_i   in  : advance the count
//   tick_o out : high for one cycle on the wrap
module pdm_seq_timer
    import pdm_seq_pkg::*;
#(
    parameter int PERIOD = PDM_SEQ_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_wrap;

    assign at_wrap = (cnt_q == CW'(PERIOD - 1));
    assign tick_o  = en_i && at_wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pdm_level_sequencer.sv
// pdm_level_sequencer
// Plays a programmed table of PDM levels, one write every PERIOD cycles,
// driving the PDM write port without host involvement per step.
// Optional build macro PDM_SEQ_LOOP_EN: when defined, playback wraps from the
// last entry back to entry 0 until stopped and done is never raised.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   cfg_we/addr/data      : table write port (accepted only in IDLE)
//   cfg_last              : last index to play, latched on start
//   start, stop           : playback control pulses (stop wins)
//   busy                  : high while playing
//   done                  : one-cycle pulse at end of one-shot playback
//   pdm_we, pdm_level     : PDM write strobe and level
//   step_idx              : table index currently presented
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | waiting for start; table writable
// ST_PLAY | stepping through the table, one write per period
module pdm_level_sequencer
    import pdm_seq_pkg::*;
#(
    parameter int LEVEL_W = PDM_SEQ_LEVEL_W,
    parameter int DEPTH   = PDM_SEQ_DEPTH,
    parameter int PERIOD  = PDM_SEQ_PERIOD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [LEVEL_W-1:0]         cfg_data,
    input  logic [$clog2(DEPTH)-1:0]   cfg_last,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic                       pdm_we,
    output logic [LEVEL_W-1:0]         pdm_level,
    output logic [$clog2(DEPTH)-1:0]   step_idx
);

    localparam int AW = $clog2(DEPTH);

    pdm_seq_state_e     state_q, state_d;
    logic [LEVEL_W-1:0] table_q [DEPTH];
    logic [LEVEL_W-1:0] table_d [DEPTH];
    logic [AW-1:0]      last_q, last_d;
    logic [AW-1:0]      step_q, step_d;
    logic [AW-1:0]      step_nx;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               we_q, we_d;
    logic               done_q, done_d;
    logic               tick;
    logic               timer_clr;

    // Counter is held at 0 outside playback so the first period after a
    // start is exactly PERIOD cycles long.
    assign timer_clr = (state_q == ST_IDLE) || stop;

    pdm_seq_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (timer_clr),
        .en_i   (state_q == ST_PLAY),
        .tick_o (tick)
    );

    assign step_nx = step_q + AW'(1);

    // Table next-state; start reads table_d so a same-cycle write is seen.
    always_comb begin
        table_d = table_q;
        if (cfg_we && (state_q == ST_IDLE)) begin
            table_d[cfg_addr] = cfg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        step_d  = step_q;
        level_d = level_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_PLAY;
                    last_d  = cfg_last;
                    step_d  = '0;
                    level_d = table_d[0];
                    we_d    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (step_q < last_q) begin
                        step_d  = step_nx;
                        level_d = table_q[step_nx];
                        we_d    = 1'b1;
                    end else begin
`ifdef PDM_SEQ_LOOP_EN
                        step_d  = '0;
                        level_d = table_q[0];
                        we_d    = 1'b1;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            step_q  <= '0;
            level_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            step_q  <= step_d;
            level_q <= level_d;
            we_q    <= we_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign busy      = (state_q == ST_PLAY);
    assign done      = done_q;
    assign pdm_we    = we_q;
    assign pdm_level = level_q;
    assign step_idx  = step_q;

endmodule

// File: tb/tb_pdm_level_sequencer.sv
// tb_pdm_level_sequencer
// Directed bench for pdm_level_sequencer. Time t counts edges from the start
// edge T: an input applied while t==m is sampled at edge T+m, and outputs
// observed after that edge are recorded as time m+1.
module tb_pdm_level_sequencer;

`ifdef PDM_SEQ_LOOP_EN
    localparam int LOOP = 1;
`else
    localparam int LOOP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, cfg_we, start, stop;
    logic [2:0] cfg_addr, cfg_last, step_idx;
    logic [4:0] cfg_data, pdm_level;
    logic       busy, done, pdm_we;

    pdm_level_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .pdm_we    (pdm_we),
        .pdm_level (pdm_level),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t, we_n, done_n, done_t, busy_first, busy_last;
    int viol = 0;
    int we_t [16];
    int we_l [16];
    logic       prev_we;
    logic [4:0] prev_lvl;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        t = 0; we_n = 0; done_n = 0; done_t = -1;
        busy_first = -1; busy_last = -1;
        prev_we = pdm_we; prev_lvl = pdm_level;
        for (int i = 0; i < 16; i++) begin
            we_t[i] = -1; we_l[i] = -1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        t++;
        if (pdm_we) begin
            if (we_n < 16) begin
                we_t[we_n] = t;
                we_l[we_n] = int'(pdm_level);
            end
            we_n++;
        end
        if (done) begin
            done_n++;
            done_t = t;
        end
        if (busy) begin
            if (busy_first < 0) busy_first = t;
            busy_last = t;
        end
        if (pdm_we && prev_we) viol++;
        if (!pdm_we && !reset && (pdm_level !== prev_lvl)) viol++;
        prev_we  = pdm_we;
        prev_lvl = pdm_level;
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // start is always applied at t==0; the other events at the given times (-1 = never)
    task automatic play(input int n, input int stop_at, input int rst_at,
                        input int st_at, input int we_at,
                        input logic [2:0] wa, input logic [4:0] wd);
        clear_rec();
        for (int k = 0; k < n; k++) begin
            start    = (t == 0) || (t == st_at);
            stop     = (t == stop_at);
            reset    = (t == rst_at);
            cfg_we   = (t == we_at);
            cfg_addr = wa;
            cfg_data = wd;
            cyc();
        end
        start = 1'b0; stop = 1'b0; reset = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_last = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_we",    int'(pdm_we), 0);
        chk("rst_level", int'(pdm_level), 0);
        chk("rst_step",  int'(step_idx), 0);
        reset = 1'b0;

        wr(3'd0, 5'h08);
        wr(3'd1, 5'h1A);
        wr(3'd2, 5'h0F);
        cfg_last = 3'd2;

`ifndef PDM_SEQ_LOOP_EN
        // Basic one-shot playback of three entries
        play(200, -1, -1, -1, -1, 3'd0, 5'h00);
        chk("p1_we_n",   we_n, 3);
        chk("p1_t0",     we_t[0], 1);
        chk("p1_t1",     we_t[1], 65);
        chk("p1_t2",     we_t[2], 129);
        chk("p1_l0",     we_l[0], 8'h08);
        chk("p1_l1",     we_l[1], 8'h1A);
        chk("p1_l2",     we_l[2], 8'h0F);
        chk("p1_done_n", done_n, 1);
        chk("p1_done_t", done_t, 193);
        chk("p1_bfirst", busy_first, 1);
        chk("p1_blast",  busy_last, 192);
        chk("p1_step",   int'(step_idx), 2);
        chk("p1_level",  int'(pdm_level), 8'h0F);
`endif

        // Stop mid-playback
        play(80, 70, -1, -1, -1, 3'd0, 5'h00);
        chk("p2_we_n",   we_n, 2);
        chk("p2_tlast",  we_t[1], 65);
        chk("p2_level",  int'(pdm_level), 8'h1A);
        chk("p2_done_n", done_n, 0);
        chk("p2_blast",  busy_last, 70);

        // start together with stop in IDLE: nothing starts
        play(70, 0, -1, -1, -1, 3'd0, 5'h00);
        chk("p3_we_n",   we_n, 0);
        chk("p3_busy",   busy_first, -1);

        // cfg_we and a second start during PLAY are ignored
        play(160, 150, -1, 20, 10, 3'd1, 5'h04);
        chk("p4_we_n",   we_n, 3);
        chk("p4_t1",     we_t[1], 65);
        chk("p4_t2",     we_t[2], 129);
        chk("p4_l1",     we_l[1], 8'h1A);
        chk("p4_l2",     we_l[2], 8'h0F);
        chk("p4_step",   int'(step_idx), 2);

`ifndef PDM_SEQ_LOOP_EN
        // Single entry, written in the same cycle as start
        cfg_last = 3'd0;
        play(70, -1, -1, -1, 0, 3'd0, 5'h1F);
        chk("p5_we_n",   we_n, 1);
        chk("p5_t0",     we_t[0], 1);
        chk("p5_l0",     we_l[0], 8'h1F);
        chk("p5_done_t", done_t, 65);
        chk("p5_blast",  busy_last, 64);
`else
        // Looping playback of two entries, terminated by stop
        cfg_last = 3'd1;
        play(260, 250, -1, -1, -1, 3'd0, 5'h00);
        chk("lp_we_n",   we_n, 4);
        chk("lp_t0",     we_t[0], 1);
        chk("lp_t1",     we_t[1], 65);
        chk("lp_t2",     we_t[2], 129);
        chk("lp_t3",     we_t[3], 193);
        chk("lp_l0",     we_l[0], 8'h08);
        chk("lp_l1",     we_l[1], 8'h1A);
        chk("lp_l2",     we_l[2], 8'h08);
        chk("lp_l3",     we_l[3], 8'h1A);
        chk("lp_done_n", done_n, 0);
        chk("lp_blast",  busy_last, 250);
`endif

        // Reset mid-playback clears outputs and the table
        cfg_last = 3'd2;
        play(101, -1, 100, -1, -1, 3'd0, 5'h00);
        chk("r_bfirst",  busy_first, 1);
        chk("r_busy",    int'(busy), 0);
        chk("r_done",    int'(done), 0);
        chk("r_we",      int'(pdm_we), 0);
        chk("r_level",   int'(pdm_level), 0);
        chk("r_step",    int'(step_idx), 0);
        play(200, 195, -1, -1, -1, 3'd0, 5'h00);
        chk("r2_we_n",   we_n, 3 + LOOP);
        chk("r2_l0",     we_l[0], 0);
        chk("r2_l1",     we_l[1], 0);
        chk("r2_l2",     we_l[2], 0);
        chk("r2_t2",     we_t[2], 129);

        chk("invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
